// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle around the decode stage: the request side carries {pc, inst},
// the response side carries the decoded head entry.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  // Both sides: a transfer happens on a rising clk edge where valid & ready are both high.
  // A producer holding valid must keep its payload stable until that edge, and the
  // consumer's ready may not depend combinationally on valid.
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [5:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode captured into a 2-entry FIFO skid buffer
// so fetch sees full throughput while execute applies backpressure.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int SUPPORT_M = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  decode_stage_if.slave bus,
  output logic [1:0]   state_dbg
);
  localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [5:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t      state, state_nx;
  entry_t      head, tail, dec;
  logic [31:0] inst;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [5:0]  fmt;
  logic        bad;
  logic        accept, pop, load_head, load_tail, shift;

  assign inst = bus.in_inst;
  assign op   = inst[6:0];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];

  always_comb begin
    fmt = '0;
    case (op)
      7'h33:                             fmt[F_R] = 1'b1;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: fmt[F_I] = 1'b1;
      7'h23:                             fmt[F_S] = 1'b1;
      7'h63:                             fmt[F_B] = 1'b1;
      7'h37, 7'h17:                      fmt[F_U] = 1'b1;
      7'h6F:                             fmt[F_J] = 1'b1;
      default:                           fmt      = '0;
    endcase
  end

  // An unknown opcode (including inst[1:0] != 2'b11) leaves fmt all-zero, which alone is illegal.
  always_comb begin
    bad = 1'b0;
    case (op)
      7'h63:   bad = (f3 == 3'b010) || (f3 == 3'b011);
      7'h03:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      7'h23:   bad = (f3 > 3'b010);
      7'h67:   bad = (f3 != 3'b000);
      7'h33:   bad = !((f7 == 7'b0000000) ||
                       ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                       ((SUPPORT_M != 0) && (f7 == 7'b0000001)));
      default: bad = (fmt == 6'b000000);
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.opcode  = op;
    dec.fmt     = fmt;
    dec.illegal = bad;
    dec.rd      = (fmt[F_S] || fmt[F_B]) ? 5'd0 : inst[11:7];
    dec.rs1     = (fmt[F_U] || fmt[F_J]) ? 5'd0 : inst[19:15];
    dec.rs2     = (fmt[F_R] || fmt[F_B] || fmt[F_S]) ? inst[24:20] : 5'd0;
    dec.funct3  = (fmt[F_U] || fmt[F_J]) ? 3'd0 : f3;
    dec.funct7  = fmt[F_R] ? f7 : 7'd0;
    if (fmt[F_I])      dec.imm = XLEN'($signed(inst[31:20]));
    else if (fmt[F_S]) dec.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
    else if (fmt[F_B]) dec.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    else if (fmt[F_U]) dec.imm = XLEN'($signed({inst[31:12], 12'b0}));
    else if (fmt[F_J]) dec.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    else               dec.imm = '0;
  end

  assign accept = bus.in_valid && (state != FULL) && !flush;
  assign pop    = (state != EMPTY) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_head = 1'b1;
          state_nx  = ONE;
        end
        ONE: begin
          if (accept && pop) begin
            load_head = 1'b1;
          end else if (accept) begin
            load_tail = 1'b1;
            state_nx  = FULL;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        FULL: if (pop) begin
          shift    = 1'b1;
          state_nx = ONE;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head)  head <= dec;
      else if (shift) head <= tail;
      if (load_tail)  tail <= dec;
    end
  end

  assign bus.in_ready    = (state != FULL);
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_pc      = head.pc;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_funct7  = head.funct7;
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_illegal = head.illegal;
  assign state_dbg       = state;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one build with the M extension and one without, both fed the same
// stream, checked every cycle against a queue model plus hand-computed literals.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic [1:0] state_dbg1, state_dbg0;
  int tests = 0;
  int failed = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();
  decode_stage_if #(.XLEN(32), .PC_W(32)) bus_m0 ();

  assign bus_m0.in_valid  = bus.in_valid;
  assign bus_m0.in_pc     = bus.in_pc;
  assign bus_m0.in_inst   = bus.in_inst;
  assign bus_m0.out_ready = bus.out_ready;

  decode_stage #(.XLEN(32), .PC_W(32), .SUPPORT_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .state_dbg(state_dbg1));
  decode_stage #(.XLEN(32), .PC_W(32), .SUPPORT_M(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_m0), .state_dbg(state_dbg0));

  logic [102:0] got1, got0;
  assign got1 = {bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
                 bus.out_funct3, bus.out_funct7, bus.out_imm, bus.out_fmt, bus.out_illegal};
  assign got0 = {bus_m0.out_pc, bus_m0.out_opcode, bus_m0.out_rd, bus_m0.out_rs1, bus_m0.out_rs2,
                 bus_m0.out_funct3, bus_m0.out_funct7, bus_m0.out_imm, bus_m0.out_fmt,
                 bus_m0.out_illegal};

  // Expected decoded entry, packed in the same order as got1/got0.
  function automatic logic [102:0] model(input logic [31:0] pc, input logic [31:0] inst,
                                         input bit m);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [5:0] fmt;
    logic [31:0] imm;
    logic ill;
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    case (op)
      7'h33:                             fmt = 6'b000001;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: fmt = 6'b000010;
      7'h23:                             fmt = 6'b000100;
      7'h63:                             fmt = 6'b001000;
      7'h37, 7'h17:                      fmt = 6'b010000;
      7'h6F:                             fmt = 6'b100000;
      default:                           fmt = 6'b000000;
    endcase
    case (fmt)
      6'b000010: imm = {{20{inst[31]}}, inst[31:20]};
      6'b000100: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      6'b001000: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      6'b010000: imm = {inst[31:12], 12'h000};
      6'b100000: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:   imm = 32'h0;
    endcase
    ill = (fmt == 6'b000000);
    if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) ill = 1'b1;
    if (op == 7'h03 && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ill = 1'b1;
    if (op == 7'h23 && f3 > 3'd2) ill = 1'b1;
    if (op == 7'h67 && f3 != 3'd0) ill = 1'b1;
    if (op == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                         (f7 == 7'h01 && m))) ill = 1'b1;
    return {pc, op,
            (fmt == 6'b000100 || fmt == 6'b001000) ? 5'd0 : inst[11:7],
            (fmt == 6'b010000 || fmt == 6'b100000) ? 5'd0 : inst[19:15],
            (fmt == 6'b000001 || fmt == 6'b000100 || fmt == 6'b001000) ? inst[24:20] : 5'd0,
            (fmt == 6'b010000 || fmt == 6'b100000) ? 3'd0 : f3,
            (fmt == 6'b000001) ? f7 : 7'd0,
            imm, fmt, ill};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: a 2-deep FIFO of accepted {pc, inst}.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      int n;
      bit acc, pp;
      n   = exp_q.size();
      acc = bus.in_valid && (n < 2) && !flush;
      pp  = (n > 0) && bus.out_ready;
      if (flush) exp_q.delete();
      else begin
        if (pp) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({bus.in_pc, bus.in_inst});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst out_valid", bus.out_valid, 1'b0);
      check("rst in_ready", bus.in_ready, 1'b1);
      check("rst outputs", got1, '0);
    end else begin
      check("m1 in_ready", bus.in_ready, exp_q.size() < 2);
      check("m1 out_valid", bus.out_valid, exp_q.size() > 0);
      check("m0 in_ready", bus_m0.in_ready, exp_q.size() < 2);
      check("m0 out_valid", bus_m0.out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("m1 head", got1, model(exp_q[0][63:32], exp_q[0][31:0], 1'b1));
        check("m0 head", got0, model(exp_q[0][63:32], exp_q[0][31:0], 1'b0));
      end
    end
  end

  logic [31:0] t5_inst[11] = '{32'h00000000, 32'h02000033, 32'h0000A023, 32'h0000B023,
                               32'h00006003, 32'h00002063, 32'h00001067, 32'h40001033,
                               32'h00000012, 32'h0040006F, 32'h40005033};
  logic        t5_ill[11]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [5:0]  t5_fmt[11]  = '{6'h00, 6'h01, 6'h04, 6'h04, 6'h02, 6'h08, 6'h02, 6'h01,
                               6'h00, 6'h20, 6'h01};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_imm", bus.out_imm, 32'h0);
    check("reset out_fmt", bus.out_fmt, 6'h0);
    rst_n = 1'b1;

    // T1: addi x1, x0, -1
    step(1'b1, 32'h100, 32'hFFF00093, 1'b1, 1'b0);
    check("t1 valid", bus.out_valid, 1'b1);
    check("t1 fmt", bus.out_fmt, 6'b000010);
    check("t1 rd", bus.out_rd, 5'd1);
    check("t1 rs1", bus.out_rs1, 5'd0);
    check("t1 imm", bus.out_imm, 32'hFFFFFFFF);
    check("t1 illegal", bus.out_illegal, 1'b0);

    // T2: lui then beq
    step(1'b1, 32'h104, 32'h12345037, 1'b1, 1'b0);
    check("t2 lui rd", bus.out_rd, 5'd0);
    check("t2 lui imm", bus.out_imm, 32'h12345000);
    check("t2 lui fmt", bus.out_fmt, 6'b010000);
    step(1'b1, 32'h108, 32'hFE208EE3, 1'b1, 1'b0);
    check("t2 beq rs1", bus.out_rs1, 5'd1);
    check("t2 beq rs2", bus.out_rs2, 5'd2);
    check("t2 beq rd", bus.out_rd, 5'd0);
    check("t2 beq imm", bus.out_imm, 32'hFFFFFFFC);
    check("t2 beq fmt", bus.out_fmt, 6'b001000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // T3: backpressure with three offers
    step(1'b1, 32'h200, 32'h00208133, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'h40208133, 1'b0, 1'b0);
    check("t3 full in_ready", bus.in_ready, 1'b0);
    check("t3 head pc", bus.out_pc, 32'h200);
    step(1'b1, 32'h208, 32'h02208133, 1'b0, 1'b0);
    check("t3 stall pc", bus.out_pc, 32'h200);
    step(1'b1, 32'h208, 32'h02208133, 1'b1, 1'b0);
    check("t3 second pc", bus.out_pc, 32'h204);
    check("t3 second valid", bus.out_valid, 1'b1);
    step(1'b1, 32'h208, 32'h02208133, 1'b1, 1'b0);
    check("t3 third pc", bus.out_pc, 32'h208);
    check("t3 third valid", bus.out_valid, 1'b1);
    check("t3 mul m0 illegal", bus_m0.out_illegal, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("t3 drained", bus.out_valid, 1'b0);

    // T4: flush while full and offering
    step(1'b1, 32'h300, 32'h0040006F, 1'b0, 1'b0);
    step(1'b1, 32'h304, 32'hFE112E23, 1'b0, 1'b0);
    step(1'b1, 32'h308, 32'h12345037, 1'b0, 1'b1);
    check("t4 out_valid", bus.out_valid, 1'b0);
    check("t4 in_ready", bus.in_ready, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("t4 nothing emitted", bus.out_valid, 1'b0);

    // T5: legality table
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 32'h400 + 32'(4 * i), t5_inst[i], 1'b1, 1'b0);
      check($sformatf("t5 illegal %h", t5_inst[i]), bus.out_illegal, t5_ill[i]);
      check($sformatf("t5 fmt %h", t5_inst[i]), bus.out_fmt, t5_fmt[i]);
      if (i == 1) check("t5 m0 mul illegal", bus_m0.out_illegal, 1'b1);
      if (i == 9) check("t5 jal imm", bus.out_imm, 32'h4);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // T6: asynchronous reset between edges
    step(1'b1, 32'h500, 32'h00208133, 1'b0, 1'b0);
    step(1'b1, 32'h504, 32'h40208133, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6 out_valid", bus.out_valid, 1'b0);
    check("t6 in_ready", bus.in_ready, 1'b1);
    check("t6 outputs zero", got1, '0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 32'h600, 32'hFFF00093, 1'b1, 1'b0);
    check("t6 post pc", bus.out_pc, 32'h600);
    check("t6 post rd", bus.out_rd, 5'd1);
    check("t6 post imm", bus.out_imm, 32'hFFFFFFFF);
    check("t6 post fmt", bus.out_fmt, 6'b000010);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
